sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/pn_meas_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/sample_framer.sv | 166 ++++++++++++++++
 tb/tb_sample_framer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_meas_pkg.sv
// Shared definitions for the sample framer: FSM encodings, header magic and frame counter width.
// The HDR state exists only when SAMPLE_FRAMER_HDR_EN is defined.
package pn_meas_pkg;

    localparam int          FRAME_CNT_W = 16;
    localparam logic [15:0] HDR_MAGIC   = 16'hA5A5;

`ifdef SAMPLE_FRAMER_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_STREAM = 2'd2
    } frame_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd2
    } frame_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with level, full and empty.
// o_rd_next exposes the word behind the head so a registered consumer can pre-load it on a pop.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_rd_en,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic [DATA_WIDTH-1:0]     o_rd_next,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           w_level;
    logic [AW-1:0]         w_next_addr;
    logic                  w_do_wr;
    logic                  w_do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign o_full      = (w_level == FULL_LEVEL);
    assign o_empty     = (w_level == '0);
    assign o_level     = w_level;
    assign w_do_wr     = i_wr_en && !o_full;
    assign w_do_rd     = i_rd_en && !o_empty;
    assign w_next_addr = r_rd_ptr[AW-1:0] + 1'b1;
    assign o_rd_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign o_rd_next   = r_mem[w_next_addr];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_framer.sv
// Buffers decimated samples and streams them out in frames of FRAME_LEN words with a valid/ready port.
// Define SAMPLE_FRAMER_HDR_EN to prefix each frame with a {0xA5A5, zeros, frame_cnt} header word.
module sample_framer
    import pn_meas_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_in_vld,
    input  logic                          enable,
    input  logic                          clear_ovf,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          overflow,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    // Output handshake: a word moves on a rising edge where m_valid=1 and m_ready=1;
    // while m_valid=1 and m_ready=0 the m_data/m_valid/m_last registers hold their values.

    localparam int             LW             = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]  FRAME_LEN_L    = LW'(FRAME_LEN);
    localparam logic [LW-1:0]  LAST_IDX       = LW'(FRAME_LEN - 1);
    localparam logic [LW-1:0]  PRE_LAST_IDX   = LW'(FRAME_LEN - 2);
    localparam logic           ONE_WORD_FRAME = (FRAME_LEN == 1);

    frame_state_t             r_state;
    logic [LW-1:0]            r_word_idx;
    logic [DATA_WIDTH-1:0]    r_m_data;
    logic                     r_m_valid;
    logic                     r_m_last;
    logic                     r_overflow;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;

    logic                     w_wr_req;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_frame_ready;
    logic [DATA_WIDTH-1:0]    w_head;
    logic [DATA_WIDTH-1:0]    w_next;
    logic [LW-1:0]            w_level;

    // Full is judged before any same-cycle pop, so a read never rescues a write.
    assign w_wr_req      = data_in_vld && enable;
    assign w_push        = w_wr_req && !w_full;
    assign w_drop        = w_wr_req && w_full;
    assign w_pop         = (r_state == ST_STREAM) && r_m_valid && m_ready;
    assign w_frame_ready = !w_empty && (w_level >= FRAME_LEN_L);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (w_push),
        .i_wr_data  (data_in),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_rd_next  (w_next),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

`ifdef SAMPLE_FRAMER_HDR_EN
    logic [DATA_WIDTH-1:0] w_header;

    always_comb begin
        w_header                       = '0;
        w_header[DATA_WIDTH-1 -: 16]   = HDR_MAGIC;
        w_header[FRAME_CNT_W-1:0]      = r_frame_cnt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // A frame only starts with a full frame already buffered, so the head and the word
    // behind it are always valid while streaming and m_data can be pre-loaded on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_idx  <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_ready) begin
                        r_m_valid  <= 1'b1;
                        r_word_idx <= '0;
`ifdef SAMPLE_FRAMER_HDR_EN
                        r_state    <= ST_HDR;
                        r_m_data   <= w_header;
                        r_m_last   <= 1'b0;
`else
                        r_state    <= ST_STREAM;
                        r_m_data   <= w_head;
                        r_m_last   <= ONE_WORD_FRAME;
`endif
                    end
                end
`ifdef SAMPLE_FRAMER_HDR_EN
                ST_HDR: begin
                    if (m_ready) begin
                        r_state  <= ST_STREAM;
                        r_m_data <= w_head;
                        r_m_last <= ONE_WORD_FRAME;
                    end
                end
`endif
                ST_STREAM: begin
                    if (m_ready) begin
                        if (r_word_idx == LAST_IDX) begin
                            r_state     <= ST_IDLE;
                            r_m_valid   <= 1'b0;
                            r_m_last    <= 1'b0;
                            r_m_data    <= '0;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_word_idx  <= r_word_idx + 1'b1;
                            r_m_data    <= w_next;
                            r_m_last    <= (r_word_idx == PRE_LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_m_data  <= '0;
                end
            endcase
        end
    end

    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign overflow   = r_overflow;
    assign frame_cnt  = r_frame_cnt;
    assign fifo_level = w_level;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sample_framer.sv
// Randomized bench for sample_framer: a queue model of buffered samples predicts every output word,
// frame boundary, level, overflow and frame count; header checks apply when SAMPLE_FRAMER_HDR_EN is defined.
module tb_sample_framer;

    localparam int DW    = 32;
    localparam int FL    = 64;
    localparam int DEPTH = 128;
    localparam int LW    = 8;
`ifdef SAMPLE_FRAMER_HDR_EN
    localparam int FRAME_WORDS = FL + 1;
`else
    localparam int FRAME_WORDS = FL;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic           clk;
    logic           rst;
    logic [DW-1:0]  data_in;
    logic           data_in_vld;
    logic           enable;
    logic           clear_ovf;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           overflow;
    logic [15:0]    frame_cnt;
    logic [LW-1:0]  fifo_level;
    logic [1:0]     dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sample_framer #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_in_vld (data_in_vld),
        .enable      (enable),
        .clear_ovf   (clear_ovf),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .overflow    (overflow),
        .frame_cnt   (frame_cnt),
        .fifo_level  (fifo_level),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks;
    int            n_fail;
    logic [DW-1:0] exp_q[$];      // samples accepted but not yet delivered, in arrival order
    logic [DW-1:0] hdr_seen[$];
    int            m_idx;         // words already delivered in the current frame
    logic          m_ovf;
    logic [15:0]   m_frames;
    int            words_seen;
    int            idle_wait;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          gap_due;
    logic          reset_due;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check what the DUT shows now, predict the effect of the coming edge, then step.
    task automatic cycle();
        logic          xfer;
        logic          full;
        logic          drop;
        logic          exp_l;
        logic [DW-1:0] exp_w;
        check("fifo_level", fifo_level, exp_q.size());
        check("overflow", overflow, m_ovf);
        check("frame_cnt", frame_cnt, m_frames);
        if (reset_due) begin
            check("rst_valid", m_valid, 0);
            check("rst_last", m_last, 0);
            check("rst_data", m_data, 0);
            reset_due = 1'b0;
        end
        if (gap_due) begin
            check("frame_gap", m_valid, 0);
            gap_due = 1'b0;
        end
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_last, prev_last);
        end
        if (m_idx == 0 && exp_q.size() < FL) check("early_start", m_valid, 0);
        if (m_idx == 0 && exp_q.size() >= FL && !m_valid) idle_wait++;
        else idle_wait = 0;
        if (idle_wait > 0) check("start_latency", idle_wait > 2, 0);

        xfer       = !rst && m_valid && m_ready;
        prev_stall = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        full       = (exp_q.size() == DEPTH);
        drop       = data_in_vld && enable && full;

        if (xfer) begin
            words_seen++;
            exp_w = '0;
`ifdef SAMPLE_FRAMER_HDR_EN
            if (m_idx == 0) begin
                exp_w = {16'hA5A5, m_frames};
                hdr_seen.push_back(m_data);
            end else begin
                check("word_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
            end
`else
            check("word_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) exp_w = exp_q.pop_front();
`endif
            check("m_data", m_data, exp_w);
            exp_l = (m_idx == FRAME_WORDS - 1);
            check("m_last", m_last, exp_l);
            if (exp_l) begin
                m_idx = 0;
                m_frames++;
                gap_due = 1'b1;
            end else begin
                m_idx++;
            end
        end

        if (!rst) begin
            if (drop) m_ovf = 1'b1;
            else if (data_in_vld && enable) exp_q.push_back(data_in);
            if (clear_ovf && !drop) m_ovf = 1'b0;
        end

        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_idx      = 0;
            m_ovf      = 1'b0;
            m_frames   = '0;
            reset_due  = 1'b1;
            gap_due    = 1'b0;
            prev_stall = 1'b0;
            idle_wait  = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] value);
        data_in     = value;
        data_in_vld = 1'b1;
        cycle();
        data_in_vld = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready random
    task automatic drain(input int mode, input int max_cycles);
        int  n;
        bit  done;
        n    = 0;
        done = (m_idx == 0 && exp_q.size() < FL && !m_valid);
        while (!done && n < max_cycles) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            n++;
            done = (m_idx == 0 && exp_q.size() < FL && !m_valid);
        end
        check("drain_done", done, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int n;
        n_checks    = 0;
        n_fail      = 0;
        m_idx       = 0;
        m_ovf       = 1'b0;
        m_frames    = '0;
        words_seen  = 0;
        idle_wait   = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        gap_due     = 1'b0;
        reset_due   = 1'b0;
        rst         = 1'b1;
        data_in     = '0;
        data_in_vld = 1'b0;
        enable      = 1'b0;
        clear_ovf   = 1'b0;
        m_ready     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // One frame of 1..64 with a always-ready sink.
        enable  = 1'b1;
        m_ready = 1'b1;
        w0      = words_seen;
        for (int i = 1; i <= FL; i++) push(DW'(i));
        drain(0, 400);
        check("s1_frame_cnt", frame_cnt, 1);
        check("s1_words", words_seen - w0, FRAME_WORDS);

        // Sink toggling every cycle while samples stream in.
        w0 = words_seen;
        for (int i = 0; i < FL; i++) begin
            m_ready = ~m_ready;
            push($urandom);
        end
        drain(1, 600);
        check("s2_frame_cnt", frame_cnt, 2);
        check("s2_words", words_seen - w0, FRAME_WORDS);

        // Stalled sink: 130 samples into a 128-deep buffer.
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push(32'h1000_0000 + DW'(i));
        idle(2);
        check("s3_level_full", fifo_level, DEPTH);
        check("s3_overflow_set", overflow, 1);
        clear_ovf   = 1'b1;
        data_in     = 32'hDEAD_BEEF;
        data_in_vld = 1'b1;
        cycle();
        data_in_vld = 1'b0;
        clear_ovf   = 1'b0;
        cycle();
        check("s3_set_wins", overflow, 1);
        clear_ovf = 1'b1;
        cycle();
        clear_ovf = 1'b0;
        cycle();
        check("s3_overflow_clr", overflow, 0);
        w0 = words_seen;
        drain(0, 600);
        check("s3_words", words_seen - w0, 2 * FRAME_WORDS);
        check("s3_level_empty", fifo_level, 0);

        // Enable drops after 100 samples; later valids must be ignored.
        m_ready = 1'b1;
        w0      = words_seen;
        for (int i = 0; i < 100; i++) push(32'h2000_0000 + DW'(i));
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h3000_0000 + DW'(i));
        drain(0, 400);
        idle(100);
        check("s4_words", words_seen - w0, FRAME_WORDS);
        check("s4_level_left", fifo_level, 36);

        // Random traffic with random backpressure and occasional clear.
        for (int i = 0; i < 1500; i++) begin
            data_in     = $urandom;
            data_in_vld = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 9) != 0);
            m_ready     = 1'($urandom_range(0, 1));
            clear_ovf   = ($urandom_range(0, 31) == 0);
            cycle();
        end
        data_in_vld = 1'b0;
        clear_ovf   = 1'b0;
        enable      = 1'b1;
        drain(2, 3000);

        // Reset while the 30th word of a frame is on the bus.
        m_ready = 1'b0;
        for (int i = 0; i < FL; i++) push($urandom);
        m_ready = 1'b1;
        n = 0;
        while (m_idx != 29 && n < 300) begin
            cycle();
            n++;
        end
        check("s6_reach_word30", m_idx, 29);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("s6_valid_low", m_valid, 0);
        check("s6_level_zero", fifo_level, 0);
        check("s6_frames_zero", frame_cnt, 0);
        idle(5);

`ifdef SAMPLE_FRAMER_HDR_EN
        // Two framed bursts with header words.
        hdr_seen.delete();
        w0      = words_seen;
        m_ready = 1'b1;
        for (int i = 0; i < 2 * FL; i++) push(32'h4000_0000 + DW'(i));
        drain(0, 600);
        check("hdr_count", hdr_seen.size(), 2);
        if (hdr_seen.size() == 2) begin
            check("hdr_first", hdr_seen[0], 32'hA5A5_0000);
            check("hdr_second", hdr_seen[1], 32'hA5A5_0001);
        end
        check("hdr_words", words_seen - w0, 2 * 65);
`endif

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
